// File: rtl/block_shifter.sv
// Moving-block row for a stacker game: a block pattern shifts left/right on game
// ticks until the player stops it, then it is ANDed with the row beneath it.
module block_shifter #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 1,
  parameter int WRAP     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] blockLoc,
  input  logic [WIDTH-1:0] belowRow,
  input  logic             stopBtn,
  output logic [WIDTH-1:0] newBlockLoc,
  output logic [WIDTH-1:0] placedRow,
  output logic             placedValid,
  output logic             gameOver,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PLACE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic             dir_left;
  logic [DW-1:0]    div;
  logic             stop_q;
  logic             stop_edge;
  logic             div_wrap;
  logic             load_ok;
  logic [WIDTH-1:0] blk;
  logic [WIDTH-1:0] moved;
  logic             dir_moved;

  assign stop_edge   = stopBtn & ~stop_q;
  assign div_wrap    = (div == DW'(TICK_DIV - 1));
  assign load_ok     = load && (blockLoc != '0);
  assign newBlockLoc = blk;
  assign fsm_state   = state;

  // One-cell move candidate; in bounce mode a blocked edge reverses direction
  // and a block that touches both edges stays put.
  always_comb begin
    moved     = blk;
    dir_moved = dir_left;
    if (WRAP != 0) begin
      if (dir_left) moved = {blk[WIDTH-2:0], blk[WIDTH-1]};
      else          moved = {blk[0], blk[WIDTH-1:1]};
    end else if (!dir_left) begin
      if (!blk[0]) begin
        moved = blk >> 1;
      end else if (!blk[WIDTH-1]) begin
        moved     = blk << 1;
        dir_moved = 1'b1;
      end
    end else begin
      if (!blk[WIDTH-1]) begin
        moved = blk << 1;
      end else if (!blk[0]) begin
        moved     = blk >> 1;
        dir_moved = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_ok) state_next = SHIFT;
      SHIFT:   if (stop_edge) state_next = PLACE;
      PLACE:   state_next = (placedRow == '0) ? OVER : IDLE;
      default: state_next = OVER;
    endcase
  end

  always_comb begin
    placedValid = (state == PLACE);
    busy        = (state == SHIFT) || (state == PLACE);
  end

  // placedRow is captured on the stop edge so it is already valid during PLACE.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk       <= '0;
      placedRow <= '0;
      gameOver  <= 1'b0;
      dir_left  <= 1'b0;
      div       <= '0;
      stop_q    <= 1'b0;
    end else begin
      stop_q <= stopBtn;
      case (state)
        IDLE: begin
          if (load_ok) begin
            blk      <= blockLoc;
            dir_left <= 1'b0;
            div      <= '0;
          end
        end
        SHIFT: begin
          if (stop_edge) begin
            placedRow <= blk & belowRow;
          end else if (tick) begin
            if (div_wrap) begin
              div      <= '0;
              blk      <= moved;
              dir_left <= dir_moved;
            end else begin
              div <= div + 1'b1;
            end
          end
        end
        PLACE: begin
          if (placedRow == '0) gameOver <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_shifter.sv
// Directed bench for block_shifter: bounce, wrap, divider, placement, game over
// and reset behaviour, with hand-computed expected rows.
module tb_block_shifter;

  logic       clk = 1'b0;
  logic       rst, tick, load, stopBtn;
  logic [7:0] blockLoc, belowRow;

  logic [7:0] blk0, prow0, blk1, prow1, blk2, prow2;
  logic       pv0, go0, busy0, pv1, go1, busy1, pv2, go2, busy2;
  logic [1:0] st0, st1, st2;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PLACE = 2'd2, S_OVER = 2'd3;

  always #5 clk = ~clk;

  block_shifter #(.WIDTH(8), .TICK_DIV(1), .WRAP(0)) u_base (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .blockLoc(blockLoc),
    .belowRow(belowRow), .stopBtn(stopBtn), .newBlockLoc(blk0), .placedRow(prow0),
    .placedValid(pv0), .gameOver(go0), .busy(busy0), .fsm_state(st0));

  block_shifter #(.WIDTH(8), .TICK_DIV(3), .WRAP(0)) u_div3 (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .blockLoc(blockLoc),
    .belowRow(belowRow), .stopBtn(stopBtn), .newBlockLoc(blk1), .placedRow(prow1),
    .placedValid(pv1), .gameOver(go1), .busy(busy1), .fsm_state(st1));

  block_shifter #(.WIDTH(8), .TICK_DIV(1), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .blockLoc(blockLoc),
    .belowRow(belowRow), .stopBtn(stopBtn), .newBlockLoc(blk2), .placedRow(prow2),
    .placedValid(pv2), .gameOver(go2), .busy(busy2), .fsm_state(st2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] pat);
    blockLoc = pat;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; load = 1'b0; stopBtn = 1'b0;
    blockLoc = '0; belowRow = '0;
    step(); step();
    check("rst_blk", blk0, 8'h00);
    check("rst_prow", prow0, 8'h00);
    check("rst_pv", pv0, 1'b0);
    check("rst_go", go0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_state", st0, S_IDLE);
    rst = 1'b0;
    step();

    do_load(8'h00);
    check("zero_load_ignored", st0, S_IDLE);

    // Divider and wrap instances, then reset mid-shift.
    do_load(8'b0000_0011);
    check("load_blk", blk0, 8'b0000_0011);
    check("load_busy", busy0, 1'b1);
    do_tick();
    check("base_bounce_first", blk0, 8'b0000_0110);
    check("wrap_rotate", blk2, 8'b1000_0001);
    check("div3_tick1", blk1, 8'b0000_0011);
    do_tick();
    check("div3_tick2", blk1, 8'b0000_0011);
    do_tick();
    check("div3_tick3", blk1, 8'b0000_0110);
    do_tick(); do_tick();
    check("div3_tick5", blk1, 8'b0000_0110);
    do_tick();
    check("div3_tick6", blk1, 8'b0000_1100);
    do_reset();
    check("midshift_rst_blk", blk0, 8'h00);
    check("midshift_rst_busy", busy0, 1'b0);
    check("midshift_rst_state", st0, S_IDLE);
    check("midshift_rst_div3", blk1, 8'h00);

    // Right-edge bounce.
    do_load(8'b0011_1000);
    do_tick(); check("rb_1", blk0, 8'b0001_1100);
    do_tick(); check("rb_2", blk0, 8'b0000_1110);
    do_tick(); check("rb_3", blk0, 8'b0000_0111);
    do_tick(); check("rb_4", blk0, 8'b0000_1110);

    // Left-edge bounce.
    do_reset();
    do_load(8'b0000_0110);
    do_tick(); check("lb_a", blk0, 8'b0000_0011);
    do_tick(); check("lb_b", blk0, 8'b0000_0110);
    do_tick(); do_tick(); do_tick(); do_tick();
    check("lb_c", blk0, 8'b0110_0000);
    do_tick(); check("lb_1", blk0, 8'b1100_0000);
    do_tick(); check("lb_2", blk0, 8'b0110_0000);
    do_tick(); check("lb_dir_right", blk0, 8'b0011_0000);

    // Partial placement.
    do_reset();
    do_load(8'b0011_1000);
    do_tick();
    belowRow = 8'b0011_1000;
    stopBtn  = 1'b1;
    step();
    check("pp_state", st0, S_PLACE);
    check("pp_prow", prow0, 8'b0001_1000);
    check("pp_pv", pv0, 1'b1);
    check("pp_go", go0, 1'b0);
    check("pp_blk_kept", blk0, 8'b0001_1100);
    step();
    check("pp_idle", st0, S_IDLE);
    check("pp_pv_drop", pv0, 1'b0);
    check("pp_prow_hold", prow0, 8'b0001_1000);

    // Stop held high across the next load: no second placement.
    do_load(8'b0000_0111);
    check("held_shift", st0, S_SHIFT);
    do_tick(); do_tick();
    check("held_no_place", st0, S_SHIFT);
    check("held_blk", blk0, 8'b0001_1100);
    do_load(8'b1111_1111);
    check("busy_load_ignored", blk0, 8'b0001_1100);
    stopBtn = 1'b0;
    step();

    // Stop and tick together: stop wins.
    belowRow = 8'b0001_1100;
    stopBtn  = 1'b1;
    tick     = 1'b1;
    step();
    tick = 1'b0;
    check("st_place", st0, S_PLACE);
    check("st_no_move", blk0, 8'b0001_1100);
    check("st_prow", prow0, 8'b0001_1100);
    step();
    check("st_idle", st0, S_IDLE);
    stopBtn = 1'b0;
    step();

    // Miss -> game over.
    do_load(8'b0000_0111);
    belowRow = 8'b1110_0000;
    stopBtn  = 1'b1;
    step();
    check("miss_prow", prow0, 8'h00);
    check("miss_pv", pv0, 1'b1);
    step();
    check("miss_go", go0, 1'b1);
    check("miss_state", st0, S_OVER);
    check("miss_pv_drop", pv0, 1'b0);
    stopBtn = 1'b0;
    tick    = 1'b1;
    do_load(8'b0011_1000);
    tick = 1'b0;
    step();
    check("over_load_ignored", blk0, 8'b0000_0111);
    check("over_go_sticky", go0, 1'b1);
    check("over_busy", busy0, 1'b0);

    // Reset clears, and wins over a simultaneous load.
    rst      = 1'b1;
    load     = 1'b1;
    blockLoc = 8'b0101_0000;
    step();
    rst  = 1'b0;
    load = 1'b0;
    check("final_rst_blk", blk0, 8'h00);
    check("final_rst_go", go0, 1'b0);
    check("final_rst_prow", prow0, 8'h00);
    check("final_rst_state", st0, S_IDLE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/block_shifter.md
BLOCK_SHIFTER -- requirements
Module: block_shifter

Interface
REQ-001 Parameter WIDTH, default 8, row width in cells (>=2).
REQ-002 Parameter TICK_DIV, default 1, number of tick pulses per one-cell move (>=1).
REQ-003 Parameter WRAP, default 0, 0 = bounce at the row edges, 1 = rotate around the row edges.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 tick  input  1  one-cycle game-speed pulse (the adjusted clock pulse), sampled on clk.
REQ-007 load  input  1  one-cycle request to start a new moving block.
REQ-008 blockLoc  input  WIDTH  initial block pattern, captured on an accepted load.
REQ-009 belowRow  input  WIDTH  settled row directly beneath the moving block; used for the overlap check.
REQ-010 stopBtn  input  1  player stop button, level signal, synchronised externally.
REQ-011 newBlockLoc  output  WIDTH  current moving-block pattern.
REQ-012 placedRow  output  WIDTH  result of the last placement, equal to moving block AND belowRow.
REQ-013 placedValid  output  1  one-cycle pulse when placedRow updates.
REQ-014 gameOver  output  1  sticky flag, set when a placement leaves no overlapping cells.
REQ-015 busy  output  1  high while in SHIFT or PLACE.

Function
REQ-016 FSM states: IDLE, SHIFT, PLACE, OVER; encoding is free.
REQ-017 IDLE: load=1 with blockLoc!=0 -> capture blockLoc, direction=right, divider=0, next state SHIFT; load with blockLoc==0 is ignored.
REQ-018 Stop detection is rising-edge only: stopEdge = stopBtn & ~stopBtn_q, where stopBtn_q is registered every cycle in every state.
REQ-019 SHIFT: stopEdge -> PLACE, and the block does not move that cycle, even if tick=1 (stop wins).
REQ-020 SHIFT: tick=1 without stopEdge -> divider increments; when divider reaches TICK_DIV-1 it returns to 0 and the block moves one cell.
REQ-021 Move right is a logical shift toward bit 0; move left is a logical shift toward bit WIDTH-1.
REQ-022 Bounce (WRAP=0): if the move would drop a 1 off the edge, direction flips and the block moves one cell the opposite way on the same move.
REQ-023 Bounce (WRAP=0): a block occupying all WIDTH bits, or touching both edges, holds position and keeps its direction.
REQ-024 WRAP=1: the move is a rotate in the current direction; direction never changes.
REQ-025 PLACE: placedRow <= newBlockLoc & belowRow, and placedValid=1 for exactly this cycle.
REQ-026 PLACE: if the AND result is zero, gameOver <= 1 and next state OVER; otherwise next state IDLE and newBlockLoc is left unchanged.
REQ-027 OVER: all inputs are ignored, all outputs hold, and only rst leaves this state.
REQ-028 load while busy is ignored; blockLoc changes outside an accepted load have no effect.
REQ-029 Latency: load to first move = TICK_DIV ticks after entry to SHIFT; stop edge to placedValid = 1 clk.
REQ-030 The block never gains or loses 1-bits while moving, in either mode.

Reset
REQ-031 rst=1 on a clk edge forces the following from any state, including mid-SHIFT and PLACE: state IDLE, newBlockLoc=0, placedRow=0, placedValid=0, gameOver=0, busy=0, direction=right, divider=0, stopBtn_q=0.
REQ-032 While rst is high, rst takes priority over load, tick and stopBtn.

Verification (WIDTH=8, TICK_DIV=1, WRAP=0 unless stated)
REQ-033 Right-edge bounce: load 00111000, then 4 ticks -> newBlockLoc 00011100, 00001110, 00000111, 00001110.
REQ-034 Left-edge bounce: block 01100000 moving left, then 2 ticks -> 11000000, 01100000 (direction now right).
REQ-035 Partial placement: block 00011100, belowRow 00111000, stop edge -> next cycle placedRow=00011000, placedValid=1 for one cycle, gameOver=0, state IDLE.
REQ-036 Miss: block 00000111, belowRow 11100000, stop edge -> placedRow=0, gameOver=1 sticky; a following load is ignored; rst clears everything.
REQ-037 Stop and tick together: tick=1 and stop edge in the same cycle -> no move, PLACE entered.
REQ-038 Stop handling: stopBtn held high across two loads -> no second placement.
REQ-039 Reset mid-shift: rst during SHIFT -> all outputs 0 on the next cycle.
REQ-040 TICK_DIV=3 divider: a move occurs every 3rd tick.
REQ-041 WRAP=1: block 00000011, 1 tick -> 10000001.
